tlp_tap_mux: RTL



---
 rtl/tlp_tap_mux.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tlp_tap_mux.sv
// Round-robin, packet-granular merge of the CQ/CC/RQ/RC TLP streams into fixed OUT_BEATS-beat slots.
// Optional per-direction statistics counters are compiled in when TLP_TAP_STATS_EN is defined.
module tlp_tap_mux #(
    parameter int OUT_BEATS = 4
) (
    input  logic             clk156,
    input  logic             sys_rst_n,
    output logic [3:0]       src_rd_en,
    input  logic [3:0][73:0] src_dout,
    input  logic [3:0]       src_empty,
    output logic             wr_en,
    output logic [75:0]      din,
    input  logic             full
`ifdef TLP_TAP_STATS_EN
    ,
    output logic [3:0][31:0] stat_pkt,
    output logic [3:0][31:0] stat_trunc,
    output logic [3:0][31:0] stat_pad
`endif
);

    typedef enum logic [1:0] {ARB, COPY, PAD, DRAIN} state_e;

    localparam logic [7:0] LAST_BEAT = 8'(OUT_BEATS - 1);

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]  beat_q, beat_d;

    logic [73:0] cur_word;
    logic        src_valid;
    logic        src_last;
    logic        last_beat;
    logic        copy_fire;
    logic        pad_fire;
    logic        drain_pop;
    logic        hit;
    logic [1:0]  hit_idx;
    logic [63:0] masked_data;

    // Source word layout: {tkeep[73:66], tdata[65:2], tlast[1], tuser[0]}.
    assign cur_word  = src_dout[grant_q];
    assign src_valid = !src_empty[grant_q];
    assign src_last  = cur_word[1];
    assign last_beat = (beat_q == LAST_BEAT);
    assign copy_fire = (state_q == COPY) && src_valid && !full;
    assign pad_fire  = (state_q == PAD) && !full;
    assign drain_pop = (state_q == DRAIN) && src_valid;

    always_comb begin : arb_search
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        hit     = 1'b0;
        hit_idx = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!hit && !src_empty[rr_ptr_q + 2'(i)]) begin
                hit     = 1'b1;
                hit_idx = rr_ptr_q + 2'(i);
            end
        end
    end

    always_comb begin : byte_mask
        masked_data = '0;
        for (int b = 0; b < 8; b++) begin
            masked_data[8*b +: 8] = cur_word[66 + b] ? cur_word[2 + 8*b +: 8] : 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin : state_reg
        if (!sys_rst_n) begin
            state_q  <= ARB;
            grant_q  <= 2'd0;
            rr_ptr_q <= 2'd0;
            beat_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            ARB: begin
                if (hit) begin
                    grant_d  = hit_idx;
                    rr_ptr_d = hit_idx + 2'd1;
                    beat_d   = 8'd0;
                    state_d  = COPY;
                end
            end
            COPY: begin
                if (copy_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = src_last ? ARB : DRAIN;
                    end else if (src_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (pad_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = ARB;
                    end
                end
            end
            DRAIN: begin
                if (drain_pop && src_last) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // din stays zero outside firing cycles so an idle bus carries no stale data.
    always_comb begin : outputs
        src_rd_en = 4'b0;
        wr_en     = 1'b0;
        din       = '0;
        if (copy_fire) begin
            src_rd_en[grant_q] = 1'b1;
            wr_en              = 1'b1;
            din                = {grant_q, 8'hFF, masked_data, last_beat, cur_word[0]};
        end
        if (pad_fire) begin
            wr_en = 1'b1;
            din   = {grant_q, 8'hFF, 64'h0, last_beat, 1'b0};
        end
        if (drain_pop) begin
            src_rd_en[grant_q] = 1'b1;
        end
    end

`ifdef TLP_TAP_STATS_EN
    logic [3:0][31:0] pkt_q, trunc_q, pad_q;

    always_ff @(posedge clk156 or negedge sys_rst_n) begin : stats_reg
        if (!sys_rst_n) begin
            pkt_q   <= '0;
            trunc_q <= '0;
            pad_q   <= '0;
        end else begin
            if ((copy_fire || pad_fire) && last_beat) begin
                pkt_q[grant_q] <= pkt_q[grant_q] + 32'd1;
            end
            if (copy_fire && last_beat && !src_last) begin
                trunc_q[grant_q] <= trunc_q[grant_q] + 32'd1;
            end
            if (copy_fire && !last_beat && src_last) begin
                pad_q[grant_q] <= pad_q[grant_q] + 32'd1;
            end
        end
    end

    assign stat_pkt   = pkt_q;
    assign stat_trunc = trunc_q;
    assign stat_pad   = pad_q;
`endif

endmodule
